// File: rtl/bp_gshare_if.sv
// Fetch, resolve and prediction signal bundle between fetch/FU logic and bp_gshare.
interface bp_gshare_if #(
    parameter int unsigned NUM_SUPER = 2,
    parameter int unsigned GHR_BITS  = 7
);
    logic [NUM_SUPER-1:0][63:0]         fetch_pc;
    logic [NUM_SUPER-1:0][31:0]         fetch_ir;
    logic [NUM_SUPER-1:0]               fetch_valid;
    logic                               rollback_en;
    logic [GHR_BITS-1:0]                rollback_ghr;
    logic [63:0]                        rollback_target;
    logic [NUM_SUPER-1:0]               resolve_valid;
    logic [NUM_SUPER-1:0][63:0]         resolve_pc;
    logic [NUM_SUPER-1:0]               resolve_cond;
    logic [NUM_SUPER-1:0]               resolve_taken;
    logic [NUM_SUPER-1:0][63:0]         resolve_target;
    logic [NUM_SUPER-1:0][GHR_BITS-1:0] resolve_ghr;
    logic [NUM_SUPER-1:0]               pred_valid;
    logic [NUM_SUPER-1:0]               pred_taken;
    logic [NUM_SUPER-1:0][GHR_BITS-1:0] pred_ghr;
    logic [63:0]                        next_pc;
    logic                               redirect;

    modport master (
        output fetch_pc, fetch_ir, fetch_valid,
        output rollback_en, rollback_ghr, rollback_target,
        output resolve_valid, resolve_pc, resolve_cond, resolve_taken, resolve_target, resolve_ghr,
        input  pred_valid, pred_taken, pred_ghr, next_pc, redirect
    );

    modport slave (
        input  fetch_pc, fetch_ir, fetch_valid,
        input  rollback_en, rollback_ghr, rollback_target,
        input  resolve_valid, resolve_pc, resolve_cond, resolve_taken, resolve_target, resolve_ghr,
        output pred_valid, pred_taken, pred_ghr, next_pc, redirect
    );
endinterface

// File: rtl/bp_gshare.sv
// Superscalar gshare direction predictor with tagged BTB and per-slot history checkpoints.
// Define BP_GSHARE_EN for history-XOR indexing; otherwise the counters are indexed bimodally.
module bp_gshare #(
    parameter int unsigned NUM_SUPER    = 2,
    parameter int unsigned BHT_IDX_BITS = 7,
    parameter int unsigned BTB_IDX_BITS = 5,
    parameter int unsigned BTB_TAG_BITS = 10,
    parameter int unsigned GHR_BITS     = 7
) (
    input logic        clock,
    input logic        reset,
    bp_gshare_if.slave bus
);
    localparam int unsigned BHT_ENTRIES = 1 << BHT_IDX_BITS;
    localparam int unsigned BTB_ENTRIES = 1 << BTB_IDX_BITS;
    localparam int unsigned TAG_LSB     = BTB_IDX_BITS + 2;
    localparam int unsigned TAG_MSB     = TAG_LSB + BTB_TAG_BITS - 1;
`ifdef BP_GSHARE_EN
    localparam bit GSHARE = 1'b1;
`else
    localparam bit GSHARE = 1'b0;
`endif

    localparam logic [5:0] OP_JSR_GRP = 6'h1A;
    localparam logic [5:0] OP_BR      = 6'h30;
    localparam logic [5:0] OP_BSR     = 6'h34;

    // BLBC, BEQ, BLT, BLE, BLBS, BNE, BGE, BGT occupy opcodes 0x38..0x3F
    function automatic logic is_cond(input logic [5:0] op);
        return op[5:3] == 3'b111;
    endfunction

    function automatic logic is_uncond(input logic [5:0] op);
        return (op == OP_BR) || (op == OP_BSR) || (op == OP_JSR_GRP);
    endfunction

    logic [1:0]              cnt_q       [BHT_ENTRIES];
    logic [1:0]              cnt_d       [BHT_ENTRIES];
    logic [BTB_ENTRIES-1:0]  btb_valid_q, btb_valid_d;
    logic [BTB_TAG_BITS-1:0] btb_tag_q   [BTB_ENTRIES];
    logic [BTB_TAG_BITS-1:0] btb_tag_d   [BTB_ENTRIES];
    logic [63:0]             btb_tgt_q   [BTB_ENTRIES];
    logic [63:0]             btb_tgt_d   [BTB_ENTRIES];
    logic [GHR_BITS-1:0]     ghr_q, ghr_d;

    logic [NUM_SUPER:0][GHR_BITS-1:0] hist;
    logic [NUM_SUPER-1:0]             slot_cond, slot_uncond, slot_hit, slot_taken;
    logic [BHT_IDX_BITS-1:0]          slot_bht_idx [NUM_SUPER];
    logic [BTB_IDX_BITS-1:0]          slot_btb_idx [NUM_SUPER];
    logic                             take_found;

    logic [GHR_BITS-1:0]     res_hist    [NUM_SUPER];
    logic [BHT_IDX_BITS-1:0] res_bht_idx [NUM_SUPER];
    logic [BTB_IDX_BITS-1:0] res_btb_idx [NUM_SUPER];

    // Per-slot lookup; each slot sees the history speculatively extended by older conditional slots
    always_comb begin : slot_lookup
        slot_cond   = '0;
        slot_uncond = '0;
        slot_hit    = '0;
        slot_taken  = '0;
        hist        = '0;
        hist[0]     = GSHARE ? ghr_q : '0;
        for (int unsigned i = 0; i < NUM_SUPER; i++) begin
            slot_cond[i]    = bus.fetch_valid[i] && is_cond(bus.fetch_ir[i][31:26]);
            slot_uncond[i]  = bus.fetch_valid[i] && is_uncond(bus.fetch_ir[i][31:26]);
            slot_bht_idx[i] = bus.fetch_pc[i][BHT_IDX_BITS+1:2] ^ BHT_IDX_BITS'(hist[i]);
            slot_btb_idx[i] = bus.fetch_pc[i][BTB_IDX_BITS+1:2];
            slot_hit[i]     = btb_valid_q[slot_btb_idx[i]] &&
                              (btb_tag_q[slot_btb_idx[i]] == bus.fetch_pc[i][TAG_MSB:TAG_LSB]);
            slot_taken[i]   = slot_hit[i] &&
                              (slot_uncond[i] || (slot_cond[i] && cnt_q[slot_bht_idx[i]][1]));
            hist[i+1]       = (GSHARE && slot_cond[i]) ? GHR_BITS'({hist[i], slot_taken[i]}) : hist[i];
        end
    end

    // First taken slot squashes younger slots and supplies the redirect; rollback overrides all
    always_comb begin : select
        take_found     = 1'b0;
        bus.pred_valid = '0;
        bus.pred_taken = '0;
        bus.next_pc    = bus.fetch_pc[NUM_SUPER-1] + 64'd4;
        bus.redirect   = 1'b0;
        ghr_d          = hist[NUM_SUPER];
        for (int unsigned i = 0; i < NUM_SUPER; i++) begin
            bus.pred_ghr[i] = hist[i];
            if (!take_found) begin
                bus.pred_valid[i] = bus.fetch_valid[i];
                bus.pred_taken[i] = slot_taken[i];
                if (slot_taken[i]) begin
                    take_found   = 1'b1;
                    bus.next_pc  = btb_tgt_q[slot_btb_idx[i]];
                    bus.redirect = 1'b1;
                    ghr_d        = hist[i+1];
                end
            end
        end
        if (bus.rollback_en) begin
            bus.pred_valid = '0;
            bus.pred_taken = '0;
            bus.next_pc    = bus.rollback_target;
            bus.redirect   = 1'b1;
            ghr_d          = GSHARE ? bus.rollback_ghr : '0;
        end
    end

    // Resolve updates in slot order so same-index counter updates chain and the last BTB write wins
    always_comb begin : resolve_update
        cnt_d       = cnt_q;
        btb_valid_d = btb_valid_q;
        btb_tag_d   = btb_tag_q;
        btb_tgt_d   = btb_tgt_q;
        for (int unsigned i = 0; i < NUM_SUPER; i++) begin
            res_hist[i]    = GSHARE ? bus.resolve_ghr[i] : '0;
            res_bht_idx[i] = bus.resolve_pc[i][BHT_IDX_BITS+1:2] ^ BHT_IDX_BITS'(res_hist[i]);
            res_btb_idx[i] = bus.resolve_pc[i][BTB_IDX_BITS+1:2];
            if (bus.resolve_valid[i]) begin
                if (bus.resolve_cond[i]) begin
                    if (bus.resolve_taken[i] && (cnt_d[res_bht_idx[i]] != 2'b11)) begin
                        cnt_d[res_bht_idx[i]] = cnt_d[res_bht_idx[i]] + 2'd1;
                    end else if (!bus.resolve_taken[i] && (cnt_d[res_bht_idx[i]] != 2'b00)) begin
                        cnt_d[res_bht_idx[i]] = cnt_d[res_bht_idx[i]] - 2'd1;
                    end
                end
                if (bus.resolve_taken[i]) begin
                    btb_valid_d[res_btb_idx[i]] = 1'b1;
                    btb_tag_d[res_btb_idx[i]]   = bus.resolve_pc[i][TAG_MSB:TAG_LSB];
                    btb_tgt_d[res_btb_idx[i]]   = bus.resolve_target[i];
                end
            end
        end
    end

    // Reset blocks every table and history write in the same cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            ghr_q       <= '0;
            btb_valid_q <= '0;
            for (int unsigned e = 0; e < BHT_ENTRIES; e++) begin
                cnt_q[e] <= 2'b01;
            end
        end else begin
            ghr_q       <= ghr_d;
            cnt_q       <= cnt_d;
            btb_valid_q <= btb_valid_d;
            btb_tag_q   <= btb_tag_d;
            btb_tgt_q   <= btb_tgt_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{bus.fetch_pc, bus.fetch_ir, bus.resolve_pc, bus.rollback_ghr, bus.resolve_ghr};
endmodule

// File: tb/tb_bp_gshare.sv
// Self-checking bench for bp_gshare: directed vector table, corner sequences, random vs reference model.
`timescale 1ns/1ps
module tb_bp_gshare;
    localparam int unsigned NS = 2;
    localparam int unsigned GB = 7;
`ifdef BP_GSHARE_EN
    localparam bit GSHARE = 1'b1;
`else
    localparam bit GSHARE = 1'b0;
`endif
    localparam logic [5:0] OP_NOP = 6'h11;
    localparam logic [5:0] OP_BR  = 6'h30;
    localparam logic [5:0] OP_BSR = 6'h34;
    localparam logic [5:0] OP_JSR = 6'h1A;
    localparam logic [5:0] OP_BEQ = 6'h39;
    localparam logic [5:0] OP_BNE = 6'h3D;
    localparam logic [5:0] OP_BLT = 6'h3A;
    localparam logic [5:0] OP_BGT = 6'h3F;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    bp_gshare_if #(.NUM_SUPER(NS), .GHR_BITS(GB)) bus ();

    bp_gshare #(
        .NUM_SUPER(NS), .BHT_IDX_BITS(7), .BTB_IDX_BITS(5), .BTB_TAG_BITS(10), .GHR_BITS(GB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [1:0] ev, input logic [1:0] et,
                             input logic [63:0] en, input logic er);
        check({name, ".pred_valid"}, 64'(bus.pred_valid), 64'(ev));
        check({name, ".pred_taken"}, 64'(bus.pred_taken), 64'(et));
        check({name, ".next_pc"}, bus.next_pc, en);
        check({name, ".redirect"}, 64'(bus.redirect), 64'(er));
    endtask

    task automatic idle();
        bus.fetch_pc[0]     = 64'h4000;
        bus.fetch_pc[1]     = 64'h4004;
        bus.fetch_ir[0]     = {OP_NOP, 26'h0};
        bus.fetch_ir[1]     = {OP_NOP, 26'h0};
        bus.fetch_valid     = 2'b11;
        bus.rollback_en     = 1'b0;
        bus.rollback_ghr    = '0;
        bus.rollback_target = '0;
        bus.resolve_valid   = '0;
        bus.resolve_pc      = '0;
        bus.resolve_cond    = '0;
        bus.resolve_taken   = '0;
        bus.resolve_target  = '0;
        bus.resolve_ghr     = '0;
    endtask

    task automatic set_fetch(input logic [63:0] pc, input logic [5:0] op0, input logic [5:0] op1);
        bus.fetch_pc[0] = pc;
        bus.fetch_pc[1] = pc + 64'd4;
        bus.fetch_ir[0] = {op0, 26'h0};
        bus.fetch_ir[1] = {op1, 26'h0};
        bus.fetch_valid = 2'b11;
    endtask

    task automatic set_resolve(input int s, input logic [63:0] pc, input logic cond, input logic taken,
                               input logic [63:0] tgt);
        bus.resolve_valid[s]  = 1'b1;
        bus.resolve_pc[s]     = pc;
        bus.resolve_cond[s]   = cond;
        bus.resolve_taken[s]  = taken;
        bus.resolve_target[s] = tgt;
        bus.resolve_ghr[s]    = '0;
    endtask

    task automatic set_rollback(input logic [GB-1:0] ghr, input logic [63:0] tgt);
        bus.rollback_en     = 1'b1;
        bus.rollback_ghr    = ghr;
        bus.rollback_target = tgt;
    endtask

    // ---------------- reference model ----------------
    int unsigned m_cnt [128];
    bit          m_bv  [32];
    int unsigned m_tag [32];
    logic [63:0] m_tgt [32];
    int unsigned m_ghr;
    logic [1:0]       e_valid, e_taken;
    logic [NS*GB-1:0] e_ghr;
    logic [63:0]      e_next;
    logic             e_redir;
    int unsigned      e_ghr_next;

    function automatic bit op_cond(input logic [5:0] op);
        return op >= 6'h38;
    endfunction

    function automatic bit op_unc(input logic [5:0] op);
        return op == OP_BR || op == OP_BSR || op == OP_JSR;
    endfunction

    task automatic model_init();
        for (int e = 0; e < 128; e++) m_cnt[e] = 1;
        for (int e = 0; e < 32; e++) m_bv[e] = 1'b0;
        m_ghr = 0;
    endtask

    task automatic model_predict();
        int unsigned h, bi, bt, tg;
        bit cond, unc, hit, tk, done;
        h = m_ghr; done = 1'b0;
        e_valid = '0; e_taken = '0; e_ghr = '0; e_redir = 1'b0;
        e_next = bus.fetch_pc[NS-1] + 64'd4;
        e_ghr_next = m_ghr;
        for (int s = 0; s < NS; s++) begin
            e_ghr[s*GB +: GB] = GB'(h);
            cond = bus.fetch_valid[s] && op_cond(bus.fetch_ir[s][31:26]);
            unc  = bus.fetch_valid[s] && op_unc(bus.fetch_ir[s][31:26]);
            bi   = 32'((bus.fetch_pc[s] >> 2) % 64'd128) ^ h;
            bt   = 32'((bus.fetch_pc[s] >> 2) % 64'd32);
            tg   = 32'((bus.fetch_pc[s] >> 7) % 64'd1024);
            hit  = m_bv[bt] && (m_tag[bt] == tg);
            tk   = hit && (unc || (cond && m_cnt[bi] >= 2));
            if (!done) begin
                e_valid[s] = bus.fetch_valid[s];
                e_taken[s] = tk;
            end
            if (cond && GSHARE) h = (h * 2 + (tk ? 1 : 0)) % 128;
            if (!done) e_ghr_next = h;
            if (!done && tk) begin
                done = 1'b1; e_next = m_tgt[bt]; e_redir = 1'b1;
            end
        end
        if (bus.rollback_en) begin
            e_valid = '0; e_taken = '0; e_next = bus.rollback_target; e_redir = 1'b1;
            e_ghr_next = GSHARE ? 32'(bus.rollback_ghr) : 0;
        end
    endtask

    task automatic model_commit();
        int unsigned bi, bt;
        if (reset) begin
            model_init();
            return;
        end
        for (int s = 0; s < NS; s++) begin
            if (bus.resolve_valid[s]) begin
                if (bus.resolve_cond[s]) begin
                    bi = 32'((bus.resolve_pc[s] >> 2) % 64'd128) ^ (GSHARE ? 32'(bus.resolve_ghr[s]) : 0);
                    if (bus.resolve_taken[s]) m_cnt[bi] = (m_cnt[bi] == 3) ? 3 : m_cnt[bi] + 1;
                    else                      m_cnt[bi] = (m_cnt[bi] == 0) ? 0 : m_cnt[bi] - 1;
                end
                if (bus.resolve_taken[s]) begin
                    bt = 32'((bus.resolve_pc[s] >> 2) % 64'd32);
                    m_bv[bt]  = 1'b1;
                    m_tag[bt] = 32'((bus.resolve_pc[s] >> 7) % 64'd1024);
                    m_tgt[bt] = bus.resolve_target[s];
                end
            end
        end
        m_ghr = e_ghr_next;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [63:0] pc;      logic [5:0]  op0;
        logic        rb_en;   logic [6:0]  rb_ghr;  logic [63:0] rb_tgt;
        logic        res_en;  logic [63:0] res_pc;  logic res_cond; logic res_taken; logic [63:0] res_tgt;
        logic [1:0]  e_valid; logic [1:0]  e_taken; logic [63:0] e_next; logic e_redir; logic [6:0] e_ghr0;
    } vec_t;

    vec_t tbl [9];
    logic [5:0] op_pool [8];

    initial begin
        tbl[0] = '{64'h1000, OP_BEQ, 1'b0, 7'h00, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,
                   2'b11, 2'b00, 64'h1008, 1'b0, 7'h00};
        tbl[1] = '{64'h1000, OP_BEQ, 1'b0, 7'h00, 64'h0, 1'b1, 64'h1000, 1'b0, 1'b1, 64'h2000,
                   2'b11, 2'b00, 64'h1008, 1'b0, 7'h00};
        tbl[2] = '{64'h1000, OP_BR, 1'b0, 7'h00, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,
                   2'b01, 2'b01, 64'h2000, 1'b1, 7'h00};
        tbl[3] = '{64'h1040, OP_BNE, 1'b0, 7'h00, 64'h0, 1'b1, 64'h1040, 1'b1, 1'b1, 64'h1800,
                   2'b11, 2'b00, 64'h1048, 1'b0, 7'h00};
        tbl[4] = '{64'h4000, OP_NOP, 1'b0, 7'h00, 64'h0, 1'b1, 64'h1040, 1'b1, 1'b1, 64'h1800,
                   2'b11, 2'b00, 64'h4008, 1'b0, 7'h00};
        tbl[5] = '{64'h1040, OP_BNE, 1'b0, 7'h00, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,
                   2'b01, 2'b01, 64'h1800, 1'b1, 7'h00};
        tbl[6] = '{64'h1040, OP_BNE, 1'b0, 7'h00, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,
                   GSHARE ? 2'b11 : 2'b01, GSHARE ? 2'b00 : 2'b01,
                   GSHARE ? 64'h1048 : 64'h1800, !GSHARE, GSHARE ? 7'h01 : 7'h00};
        tbl[7] = '{64'h1040, OP_BNE, 1'b1, 7'h2A, 64'h3000, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,
                   2'b00, 2'b00, 64'h3000, 1'b1, GSHARE ? 7'h02 : 7'h00};
        tbl[8] = '{64'h4000, OP_NOP, 1'b0, 7'h00, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,
                   2'b11, 2'b00, 64'h4008, 1'b0, GSHARE ? 7'h2A : 7'h00};
        op_pool = '{OP_BEQ, OP_BNE, OP_BLT, OP_BGT, OP_BR, OP_BSR, OP_JSR, OP_NOP};

        reset = 1'b1;
        idle();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        foreach (tbl[r]) begin
            @(negedge clock);
            idle();
            set_fetch(tbl[r].pc, tbl[r].op0, OP_NOP);
            if (tbl[r].rb_en) set_rollback(tbl[r].rb_ghr, tbl[r].rb_tgt);
            if (tbl[r].res_en) set_resolve(0, tbl[r].res_pc, tbl[r].res_cond, tbl[r].res_taken, tbl[r].res_tgt);
            #1;
            check_out($sformatf("vec%0d", r), tbl[r].e_valid, tbl[r].e_taken, tbl[r].e_next, tbl[r].e_redir);
            check($sformatf("vec%0d.pred_ghr0", r), 64'(bus.pred_ghr[0]), 64'(tbl[r].e_ghr0));
        end

        // Same counter index resolved taken in both slots; same BTB index, slot 1 must win
        @(negedge clock); idle();
        set_rollback(7'h00, 64'h3000);
        set_resolve(0, 64'h2000, 1'b1, 1'b1, 64'h6000);
        set_resolve(1, 64'h2200, 1'b1, 1'b1, 64'h6600);
        @(negedge clock); idle();
        set_fetch(64'h2000, OP_BEQ, OP_NOP);
        set_resolve(0, 64'h2000, 1'b1, 1'b0, 64'h0);
        #1 check_out("btb_slot_order", 2'b11, 2'b00, 64'h2008, 1'b0);
        @(negedge clock); idle();
        set_fetch(64'h2200, OP_BEQ, OP_NOP);
        #1 check_out("cnt_dual_taken", 2'b01, 2'b01, 64'h6600, 1'b1);

        // Both not-taken from 00 must stay 00
        @(negedge clock); idle();
        set_rollback(7'h00, 64'h3000);
        set_resolve(0, 64'h2100, 1'b1, 1'b0, 64'h0);
        @(negedge clock); idle();
        set_resolve(0, 64'h2100, 1'b1, 1'b0, 64'h0);
        set_resolve(1, 64'h2300, 1'b1, 1'b0, 64'h0);
        @(negedge clock); idle();
        set_resolve(0, 64'h2100, 1'b1, 1'b1, 64'h7000);
        @(negedge clock); idle();
        set_fetch(64'h2100, OP_BEQ, OP_NOP);
        #1 check_out("cnt_dual_nt", 2'b11, 2'b00, 64'h2108, 1'b0);
        check("cnt_dual_nt.pred_ghr0", 64'(bus.pred_ghr[0]), 64'h0);

        // Reset with concurrent rollback and resolves: nothing may be written
        @(negedge clock); idle();
        reset = 1'b1;
        set_rollback(7'h55, 64'h9000);
        set_resolve(0, 64'h1040, 1'b0, 1'b1, 64'h9990);
        set_resolve(1, 64'h1040, 1'b1, 1'b1, 64'h8880);
        @(negedge clock); idle();
        reset = 1'b0;
        set_fetch(64'h1040, OP_BNE, OP_NOP);
        #1 check_out("rst_btb_miss", 2'b11, 2'b00, 64'h1048, 1'b0);
        check("rst_ghr", 64'(bus.pred_ghr[0]), 64'h0);
        @(negedge clock); idle();
        set_fetch(64'h2100, OP_BR, OP_NOP);
        set_resolve(0, 64'h1040, 1'b0, 1'b1, 64'h1800);
        #1 check_out("rst_btb_miss2", 2'b11, 2'b00, 64'h2108, 1'b0);
        @(negedge clock); idle();
        set_fetch(64'h1040, OP_BNE, OP_NOP);
        #1 check_out("rst_cnt_01", 2'b11, 2'b00, 64'h1048, 1'b0);
        @(negedge clock); idle();
        set_fetch(64'h1040, OP_BR, OP_NOP);
        #1 check_out("rst_btb_refill", 2'b01, 2'b01, 64'h1800, 1'b1);

        // Randomized traffic against the reference model
        @(negedge clock); idle();
        reset = 1'b1;
        @(posedge clock);
        model_init();
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            reset = ($urandom_range(0, 99) == 0);
            bus.fetch_pc[0] = 64'h8000 + 64'(4 * $urandom_range(0, 63));
            bus.fetch_pc[1] = bus.fetch_pc[0] + 64'd4;
            for (int s = 0; s < NS; s++) begin
                bus.fetch_ir[s]       = {op_pool[$urandom_range(0, 7)], 26'($urandom)};
                bus.resolve_valid[s]  = 1'($urandom);
                bus.resolve_pc[s]     = 64'h8000 + 64'(4 * $urandom_range(0, 63));
                bus.resolve_cond[s]   = 1'($urandom);
                bus.resolve_taken[s]  = ($urandom_range(0, 9) < 7);
                bus.resolve_target[s] = 64'h9000 + 64'(4 * $urandom_range(0, 255));
                bus.resolve_ghr[s]    = GB'($urandom_range(0, 3));
            end
            bus.fetch_valid     = 2'($urandom);
            bus.rollback_en     = ($urandom_range(0, 7) == 0);
            bus.rollback_ghr    = GB'($urandom);
            bus.rollback_target = 64'hA000 + 64'(4 * $urandom_range(0, 255));
            #1;
            model_predict();
            check($sformatf("rnd%0d.pred_valid", c), 64'(bus.pred_valid), 64'(e_valid));
            check($sformatf("rnd%0d.pred_taken", c), 64'(bus.pred_taken), 64'(e_taken));
            check($sformatf("rnd%0d.pred_ghr", c), 64'(bus.pred_ghr), 64'(e_ghr));
            check($sformatf("rnd%0d.next_pc", c), bus.next_pc, e_next);
            check($sformatf("rnd%0d.redirect", c), 64'(bus.redirect), 64'(e_redir));
            @(posedge clock);
            model_commit();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
